// File: rtl/score_sequencer.sv
// score_sequencer
//   Score-update controller. Per-source pending counters queue point events from
//   the gold, diamond and monster sources. A round-robin arbiter picks one source,
//   and a serial BCD adder applies its point value one digit per cycle to a 4-digit
//   working score. The display copy loads only on startOfFrame, and never while an
//   add is in flight, so the display cannot show a half-added value.
//
//   Optional feature: define SCORE_EXTRA_LIFE_EN to build the extra-life detector.
//   Without it, extra_life is tied low.
//
// Ports
//   clk               system clock
//   resetN            asynchronous active-low reset
//   startOfFrame      one-cycle frame-start pulse; loads the display copy
//   game_clear        synchronous clear of score, display, queues, pointer, drop_err
//   player_eat_gold   gold event pulse     (GOLD_PTS units)
//   player_eat_dimond diamond event pulse  (DIAMOND_PTS units)
//   monster_killed    monster event pulse  (MONSTER_PTS units)
//   score_digits      displayed score, 4 BCD digits, thousands in [15:12]
//   score_updated     high for the one cycle in which an event completes
//   busy              adder active or any event still pending
//   drop_err          sticky: an event arrived at a saturated pending counter
//   extra_life        one-cycle pulse on a thousands-digit increment
module score_sequencer #(
   parameter int unsigned PEND_W      = 3,
   parameter int unsigned GOLD_PTS    = 2,
   parameter int unsigned DIAMOND_PTS = 1,
   parameter int unsigned MONSTER_PTS = 5
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        game_clear,
   input  logic        player_eat_gold,
   input  logic        player_eat_dimond,
   input  logic        monster_killed,
   output logic [15:0] score_digits,
   output logic        score_updated,
   output logic        busy,
   output logic        drop_err,
   output logic        extra_life
);

   typedef enum logic [2:0] {StIdle, StAdd0, StAdd1, StAdd2, StAdd3, StDone} state_e;

   localparam logic [PEND_W-1:0] PendMax    = {PEND_W{1'b1}};
   // Last-granted starts at monster so the first search begins at gold.
   localparam logic [1:0]        SrcMonster = 2'd2;

   state_e                  state_q, state_d;
   logic [2:0][PEND_W-1:0]  pend_q, pend_d;
   logic [1:0]              last_q, last_d;
   logic [1:0]              grant_q, grant_d;
   logic [3:0]              operand_q, operand_d;
   logic                    carry_q, carry_d;
   logic [15:0]             work_q, work_d;
   logic [15:0]             disp_q, disp_d;
   logic                    drop_q, drop_d;
   logic [2:0]              events;
   logic [2:0]              dec;
   logic                    any_pend;
   logic                    adding;
   logic [1:0]              cand;
   logic [1:0]              grant_sel;
   logic                    grant_found;
   logic [3:0]              operand_sel;
   logic [1:0]              digit_idx;
   logic [3:0]              digit_op;
   logic [4:0]              digit_sum;
`ifdef SCORE_EXTRA_LIFE_EN
   logic                    el_q, el_d;
`endif

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   assign events   = {monster_killed, player_eat_dimond, player_eat_gold};
   assign any_pend = |pend_q;
   assign adding   = (state_q == StAdd0) || (state_q == StAdd1) ||
                     (state_q == StAdd2) || (state_q == StAdd3);

   // Round-robin search, starting one past the last granted source.
   always_comb begin
      cand        = last_q;
      grant_sel   = last_q;
      grant_found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cand = next_src(cand);
         if (!grant_found && (pend_q[cand] != '0)) begin
            grant_found = 1'b1;
            grant_sel   = cand;
         end
      end
   end

   always_comb begin
      case (grant_sel)
         2'd0:    operand_sel = 4'(GOLD_PTS);
         2'd1:    operand_sel = 4'(DIAMOND_PTS);
         default: operand_sel = 4'(MONSTER_PTS);
      endcase
   end

   always_comb begin
      case (state_q)
         StAdd1:  digit_idx = 2'd1;
         StAdd2:  digit_idx = 2'd2;
         StAdd3:  digit_idx = 2'd3;
         default: digit_idx = 2'd0;
      endcase
   end

   // Only the units digit receives the operand; higher digits just absorb carry.
   assign digit_op  = (state_q == StAdd0) ? operand_q : 4'd0;
   assign digit_sum = {1'b0, work_q[{digit_idx, 2'b00} +: 4]} + {1'b0, digit_op} +
                      {4'd0, carry_q};

   always_comb begin
      dec = '0;
      if (state_q == StDone) dec[grant_q] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      last_d    = last_q;
      grant_d   = grant_q;
      operand_d = operand_q;
      carry_d   = carry_q;
      work_d    = work_q;
      disp_d    = disp_q;
      drop_d    = drop_q;
`ifdef SCORE_EXTRA_LIFE_EN
      el_d      = el_q;
`endif

      // A simultaneous event and service on one counter leaves it unchanged.
      for (int i = 0; i < 3; i++) begin
         if (events[i] && !dec[i]) begin
            if (pend_q[i] == PendMax) drop_d = 1'b1;
            else                      pend_d[i] = pend_q[i] + PEND_W'(1);
         end else if (!events[i] && dec[i]) begin
            pend_d[i] = pend_q[i] - PEND_W'(1);
         end
      end

      case (state_q)
         StIdle: begin
            if (grant_found) begin
               grant_d   = grant_sel;
               operand_d = operand_sel;
               carry_d   = 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
               el_d      = 1'b0;
`endif
               state_d   = StAdd0;
            end
         end
         StAdd0, StAdd1, StAdd2, StAdd3: begin
            if (digit_sum > 5'd9) begin
               work_d[{digit_idx, 2'b00} +: 4] = 4'(digit_sum - 5'd10);
               carry_d                         = 1'b1;
            end else begin
               work_d[{digit_idx, 2'b00} +: 4] = digit_sum[3:0];
               carry_d                         = 1'b0;
            end
            case (state_q)
               StAdd0:  state_d = StAdd1;
               StAdd1:  state_d = StAdd2;
               StAdd2:  state_d = StAdd3;
               default: begin
                  state_d = StDone;
                  if (digit_sum > 5'd9) work_d = 16'h9999;
`ifdef SCORE_EXTRA_LIFE_EN
                  // A carry into a 9 saturates and leaves the digit unchanged.
                  el_d = carry_q && (work_q[15:12] != 4'd9);
`endif
               end
            endcase
         end
         StDone: begin
            last_d  = grant_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (startOfFrame && !adding) disp_d = work_q;

      if (game_clear) begin
         state_d = StIdle;
         pend_d  = '0;
         last_d  = SrcMonster;
         carry_d = 1'b0;
         work_d  = '0;
         disp_d  = '0;
         drop_d  = 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
         el_d    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= StIdle;
         pend_q    <= '0;
         last_q    <= SrcMonster;
         grant_q   <= 2'd0;
         operand_q <= 4'd0;
         carry_q   <= 1'b0;
         work_q    <= '0;
         disp_q    <= '0;
         drop_q    <= 1'b0;
`ifdef SCORE_EXTRA_LIFE_EN
         el_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
         operand_q <= operand_d;
         carry_q   <= carry_d;
         work_q    <= work_d;
         disp_q    <= disp_d;
         drop_q    <= drop_d;
`ifdef SCORE_EXTRA_LIFE_EN
         el_q      <= el_d;
`endif
      end
   end

   assign score_digits  = disp_q;
   assign score_updated = (state_q == StDone);
   assign busy          = (state_q != StIdle) || any_pend;
   assign drop_err      = drop_q;
`ifdef SCORE_EXTRA_LIFE_EN
   assign extra_life    = (state_q == StDone) && el_q;
`else
   assign extra_life    = 1'b0;
`endif

endmodule
